// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants, color codes and timing types
// Purpose : default SVGA 800x600 timing constants, 3-bit RGB color constants,
//           a timing-parameter struct and small elaboration-time helpers.
// Ports   : none (package).
package vga_pkg;

   localparam int SVGA_H_VISIBLE = 800;
   localparam int SVGA_H_FRONT   = 56;
   localparam int SVGA_H_SYNC    = 120;
   localparam int SVGA_H_BACK    = 64;
   localparam int SVGA_V_VISIBLE = 600;
   localparam int SVGA_V_FRONT   = 37;
   localparam int SVGA_V_SYNC    = 6;
   localparam int SVGA_V_BACK    = 23;

   localparam logic [2:0] BLACK   = 3'b000;
   localparam logic [2:0] BLUE    = 3'b001;
   localparam logic [2:0] GREEN   = 3'b010;
   localparam logic [2:0] CYAN    = 3'b011;
   localparam logic [2:0] RED     = 3'b100;
   localparam logic [2:0] MAGENTA = 3'b101;
   localparam logic [2:0] YELLOW  = 3'b110;
   localparam logic [2:0] WHITE   = 3'b111;

   typedef struct packed {
      logic [15:0] visible;
      logic [15:0] front;
      logic [15:0] sync;
      logic [15:0] back;
   } vga_axis_t;

   typedef struct packed {
      vga_axis_t h;
      vga_axis_t v;
      logic      h_sync_pol;
      logic      v_sync_pol;
   } vga_timing_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Counter width able to hold 0..total-1, never narrower than one bit.
   function automatic int cnt_width(input int total);
      return (total > 1) ? $clog2(total) : 1;
   endfunction

endpackage

// File: rtl/pix_tick_gen.sv
// rtl/pix_tick_gen.sv - sys_clk to pixel-rate tick divider
// Purpose : counts 0..PIX_DIV-1 while enabled; pix_ce flags the terminal count.
// Ports   : sys_clk (clock), rst (async active-high reset), en (run enable),
//           pix_ce (combinational tick, high on the terminal count while en=1).
module pix_tick_gen #(
   parameter int PIX_DIV = 1
) (
   input  logic sys_clk,
   input  logic rst,
   input  logic en,
   output logic pix_ce
);

   localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

   generate
      if (PIX_DIV < 1 || PIX_DIV > 16) begin : g_bad_pix_div
         $error("pix_tick_gen: PIX_DIV must be within 1..16");
      end
   endgenerate

   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] div_d;

   always_comb begin
      div_d  = div_q;
      pix_ce = 1'b0;
      if (en) begin
         if (div_q == DIV_LAST) begin
            div_d  = '0;
            pix_ce = 1'b1;
         end else begin
            div_d = div_q + 1'b1;
         end
      end
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

endmodule

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - parameterised VGA sync/blank/coordinate generator
// Purpose : horizontal/vertical raster counters advanced on a divided pixel
//           tick, producing registered sync, blank, coordinates and pulses.
//           Optional completed-frame counter built only when
//           VGA_TIMING_FRAME_CNT_EN is defined; otherwise frame_cnt is 0.
// Ports   : sys_clk, rst (async active-high), en (0 freezes everything),
//           pix_ce (pixel tick), hsync/vsync (at configured polarity),
//           blank, x/y (all-ones while blanked in that axis),
//           line_start, frame_start (one-cycle pulses with pix_ce),
//           frame_cnt (16-bit completed-frame count).
module vga_timing
   import vga_pkg::*;
#(
   parameter int   H_VISIBLE  = SVGA_H_VISIBLE,
   parameter int   H_FRONT    = SVGA_H_FRONT,
   parameter int   H_SYNC     = SVGA_H_SYNC,
   parameter int   H_BACK     = SVGA_H_BACK,
   parameter int   V_VISIBLE  = SVGA_V_VISIBLE,
   parameter int   V_FRONT    = SVGA_V_FRONT,
   parameter int   V_SYNC     = SVGA_V_SYNC,
   parameter int   V_BACK     = SVGA_V_BACK,
   parameter logic H_SYNC_POL = 1'b0,
   parameter logic V_SYNC_POL = 1'b0,
   parameter int   PIX_DIV    = 1,
   parameter int   COORD_W    = 11
) (
   input  logic               sys_clk,
   input  logic               rst,
   input  logic               en,
   output logic               pix_ce,
   output logic               hsync,
   output logic               vsync,
   output logic               blank,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic               line_start,
   output logic               frame_start,
   output logic [15:0]        frame_cnt
);

   localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int CNT_W        = cnt_width(max_int(H_TOTAL, V_TOTAL));
   localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

   generate
      if (H_VISIBLE >= (1 << COORD_W) || V_VISIBLE >= (1 << COORD_W)) begin : g_coord_too_narrow
         $error("vga_timing: COORD_W too narrow for the visible area");
      end
   endgenerate

   logic tick;

   pix_tick_gen #(
      .PIX_DIV (PIX_DIV)
   ) u_pix_tick_gen (
      .sys_clk (sys_clk),
      .rst     (rst),
      .en      (en),
      .pix_ce  (tick)
   );

   logic [CNT_W-1:0]   h_cnt_q, h_cnt_d;
   logic [CNT_W-1:0]   v_cnt_q, v_cnt_d;
   logic               hsync_q, hsync_d;
   logic               vsync_q, vsync_d;
   logic               blank_q, blank_d;
   logic [COORD_W-1:0] x_q, x_d;
   logic [COORD_W-1:0] y_q, y_d;
   logic               pix_ce_q, pix_ce_d;
   logic               line_start_q, line_start_d;
   logic               frame_start_q, frame_start_d;

   int h_i;
   int v_i;
   assign h_i = int'(h_cnt_q);
   assign v_i = int'(v_cnt_q);

   logic h_zero;
   logic v_zero;
   assign h_zero = (h_cnt_q == '0);
   assign v_zero = (v_cnt_q == '0);

   // Outputs are computed from the counts current at the tick, then the
   // counters advance, so registered outputs trail the counters by one tick.
   always_comb begin
      h_cnt_d       = h_cnt_q;
      v_cnt_d       = v_cnt_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      blank_d       = blank_q;
      x_d           = x_q;
      y_d           = y_q;
      pix_ce_d      = tick;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      if (tick) begin
         hsync_d       = (h_i >= H_SYNC_START && h_i < H_SYNC_END) ? H_SYNC_POL : ~H_SYNC_POL;
         vsync_d       = (v_i >= V_SYNC_START && v_i < V_SYNC_END) ? V_SYNC_POL : ~V_SYNC_POL;
         blank_d       = (h_i >= H_VISIBLE) || (v_i >= V_VISIBLE);
         x_d           = (h_i < H_VISIBLE) ? COORD_W'(h_cnt_q) : '1;
         y_d           = (v_i < V_VISIBLE) ? COORD_W'(v_cnt_q) : '1;
         line_start_d  = h_zero;
         frame_start_d = h_zero && v_zero;
         if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
         end else begin
            h_cnt_d = h_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         hsync_q       <= ~H_SYNC_POL;
         vsync_q       <= ~V_SYNC_POL;
         blank_q       <= 1'b1;
         x_q           <= '1;
         y_q           <= '1;
         pix_ce_q      <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         blank_q       <= blank_d;
         x_q           <= x_d;
         y_q           <= y_d;
         pix_ce_q      <= pix_ce_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   // A pulse registered on the last tick must not leak into a cycle where
   // the run enable has just been dropped.
   assign pix_ce      = pix_ce_q & en;
   assign line_start  = line_start_q & en;
   assign frame_start = frame_start_q & en;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign blank       = blank_q;
   assign x           = x_q;
   assign y           = y_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic        frame_seen_q, frame_seen_d;

   // The first frame_start after reset opens frame 0; each later one closes
   // a frame, so the count lags the pulse count by one.
   always_comb begin
      frame_cnt_d  = frame_cnt_q;
      frame_seen_d = frame_seen_q;
      if (tick && h_zero && v_zero) begin
         frame_seen_d = 1'b1;
         if (frame_seen_q) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         frame_cnt_q  <= 16'd0;
         frame_seen_q <= 1'b0;
      end else begin
         frame_cnt_q  <= frame_cnt_d;
         frame_seen_q <= frame_seen_d;
      end
   end

   assign frame_cnt = frame_cnt_q;
`else
   assign frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - self-checking bench for vga_timing
module tb_vga_timing;

   localparam int S_DIV = 3;

   logic sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   logic rst_s, en_s, rst_d, en_d;

   logic        pce_s, hs_s, vs_s, bl_s, ls_s, fs_s;
   logic [2:0]  x_s, y_s;
   logic [15:0] fc_s;

   logic        pce_d, hs_d, vs_d, bl_d, ls_d, fs_d;
   logic [10:0] x_d, y_d;
   logic [15:0] fc_d;

   vga_timing #(
      .H_VISIBLE (4), .H_FRONT (1), .H_SYNC (2), .H_BACK (1),
      .V_VISIBLE (3), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
      .H_SYNC_POL (1'b1), .V_SYNC_POL (1'b0),
      .PIX_DIV (S_DIV), .COORD_W (3)
   ) dut_s (
      .sys_clk (sys_clk), .rst (rst_s), .en (en_s),
      .pix_ce (pce_s), .hsync (hs_s), .vsync (vs_s), .blank (bl_s),
      .x (x_s), .y (y_s), .line_start (ls_s), .frame_start (fs_s),
      .frame_cnt (fc_s)
   );

   vga_timing dut_d (
      .sys_clk (sys_clk), .rst (rst_d), .en (en_d),
      .pix_ce (pce_d), .hsync (hs_d), .vsync (vs_d), .blank (bl_d),
      .x (x_d), .y (y_d), .line_start (ls_d), .frame_start (fs_d),
      .frame_cnt (fc_d)
   );

   typedef struct packed {
      logic        pix_ce;
      logic        hsync;
      logic        vsync;
      logic        blank;
      logic [2:0]  x;
      logic [2:0]  y;
      logic        line_start;
      logic        frame_start;
      logic [15:0] frame_cnt;
   } obs_t;

   obs_t exp_q[$];
   obs_t held;
   logic [15:0] fs_log[$];

   int n_cmp = 0;
   int n_bad = 0;
   int mdiv, mh, mv, mfc;
   bit mseen;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic obs_t reset_obs();
      obs_t o;
      o = '0;
      o.hsync = 1'b0;
      o.vsync = 1'b1;
      o.blank = 1'b1;
      o.x     = 3'b111;
      o.y     = 3'b111;
      return o;
   endfunction

   // Expected small-config outputs at raster position (h, v).
   function automatic obs_t expect_at(input int h, input int v, input int fc);
      obs_t o;
      o.pix_ce      = 1'b1;
      o.hsync       = (h >= 5 && h < 7);
      o.vsync       = !(v >= 4 && v < 5);
      o.blank       = (h >= 4) || (v >= 3);
      o.x           = (h < 4) ? 3'(h) : 3'b111;
      o.y           = (v < 3) ? 3'(v) : 3'b111;
      o.line_start  = (h == 0);
      o.frame_start = (h == 0) && (v == 0);
      o.frame_cnt   = 16'(fc);
      return o;
   endfunction

   function automatic obs_t sample_s();
      obs_t o;
      o.pix_ce = pce_s; o.hsync = hs_s; o.vsync = vs_s; o.blank = bl_s;
      o.x = x_s; o.y = y_s; o.line_start = ls_s; o.frame_start = fs_s;
      o.frame_cnt = fc_s;
      return o;
   endfunction

   task automatic compare_all(input string pfx, input obs_t o, input obs_t e);
      check_eq({pfx, "_pix_ce"},      32'(o.pix_ce),      32'(e.pix_ce));
      check_eq({pfx, "_hsync"},       32'(o.hsync),       32'(e.hsync));
      check_eq({pfx, "_vsync"},       32'(o.vsync),       32'(e.vsync));
      check_eq({pfx, "_blank"},       32'(o.blank),       32'(e.blank));
      check_eq({pfx, "_x"},           32'(o.x),           32'(e.x));
      check_eq({pfx, "_y"},           32'(o.y),           32'(e.y));
      check_eq({pfx, "_line_start"},  32'(o.line_start),  32'(e.line_start));
      check_eq({pfx, "_frame_start"}, 32'(o.frame_start), 32'(e.frame_start));
      check_eq({pfx, "_frame_cnt"},   32'(o.frame_cnt),   32'(e.frame_cnt));
   endtask

   // One sys_clk of the small DUT: model the posedge, compare at the negedge.
   task automatic cyc_s(input string pfx);
      obs_t e;
      bit   ticked;
      int   fc;
      @(posedge sys_clk);
      ticked = 1'b0;
      if (rst_s) begin
         mdiv = 0; mh = 0; mv = 0; mfc = 0; mseen = 1'b0;
         held = reset_obs();
      end else if (en_s) begin
         if (mdiv == S_DIV - 1) begin
            mdiv = 0;
`ifdef VGA_TIMING_FRAME_CNT_EN
            if (mh == 0 && mv == 0) begin
               if (mseen) mfc = (mfc + 1) & 16'hffff;
               mseen = 1'b1;
            end
            fc = mfc;
`else
            fc = 0;
`endif
            exp_q.push_back(expect_at(mh, mv, fc));
            ticked = 1'b1;
            if (mh == 7) begin
               mh = 0;
               mv = (mv == 5) ? 0 : mv + 1;
            end else begin
               mh = mh + 1;
            end
         end else begin
            mdiv = mdiv + 1;
         end
      end
      @(negedge sys_clk);
      if (ticked && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         held = e;
         held.pix_ce = 1'b0;
         held.line_start = 1'b0;
         held.frame_start = 1'b0;
      end else begin
         e = held;
      end
      compare_all(pfx, sample_s(), e);
      if (fs_s) fs_log.push_back(fc_s);
   endtask

   initial begin
      int k, first_low, low_len, period;
      rst_s = 1'b1; en_s = 1'b0; rst_d = 1'b1; en_d = 1'b0;
      held = reset_obs();
      mdiv = 0; mh = 0; mv = 0; mfc = 0; mseen = 1'b0;
      @(negedge sys_clk);

      // Reset state of both instances.
      repeat (3) cyc_s("rst");
      check_eq("d_rst_hsync", 32'(hs_d), 32'd1);
      check_eq("d_rst_vsync", 32'(vs_d), 32'd1);
      check_eq("d_rst_blank", 32'(bl_d), 32'd1);
      check_eq("d_rst_x", 32'(x_d), 32'h7ff);
      check_eq("d_rst_y", 32'(y_d), 32'h7ff);
      check_eq("d_rst_pulses", {29'd0, pce_d, ls_d, fs_d}, 32'd0);

      // Three full frames plus margin on the small config.
      rst_s = 1'b0; en_s = 1'b1;
      fs_log.delete();
      repeat (3 * 144 + 12) cyc_s("run");
      check_eq("fs_count", fs_log.size(), 32'd4);
      for (int i = 0; i < 3 && i < fs_log.size(); i++) begin
`ifdef VGA_TIMING_FRAME_CNT_EN
         check_eq("frame_cnt_seq", 32'(fs_log[i]), 32'(i));
`else
         check_eq("frame_cnt_seq", 32'(fs_log[i]), 32'd0);
`endif
      end

      // Drop enable mid-line for 50 clocks, then resume.
      k = 0;
      while (!(mh == 2 && mdiv == 1) && k < 200) begin cyc_s("pre_hold"); k++; end
      check_eq("hold_reach", 32'(k < 200), 32'd1);
      en_s = 1'b0;
      repeat (50) cyc_s("hold");
      en_s = 1'b1;
      repeat (150) cyc_s("resume");

      // Reset mid-line, then the first tick after release.
      k = 0;
      while (!(mh == 3 && mv == 1) && k < 200) begin cyc_s("pre_rst"); k++; end
      check_eq("rst_reach", 32'(k < 200), 32'd1);
      rst_s = 1'b1;
      #1;
      held = reset_obs();
      compare_all("rst_async", sample_s(), held);
      repeat (2) cyc_s("rst_hold");
      rst_s = 1'b0;
      k = 0;
      do begin cyc_s("post_rst"); k++; end while (!pce_s && k < 10);
      check_eq("post_rst_tick", 32'(pce_s), 32'd1);
      check_eq("post_rst_x", 32'(x_s), 32'd0);
      check_eq("post_rst_y", 32'(y_s), 32'd0);
      check_eq("post_rst_fs", 32'(fs_s), 32'd1);
      repeat (100) cyc_s("post_run");
      check_eq("sb_empty", exp_q.size(), 32'd0);

      // Default SVGA timing: line period and hsync window.
      en_s = 1'b0;
      rst_d = 1'b0; en_d = 1'b1;
      k = 0;
      do begin @(negedge sys_clk); k++; end while (!ls_d && k < 20);
      check_eq("d_first_ls", 32'(ls_d), 32'd1);
      check_eq("d_first_fs", 32'(fs_d), 32'd1);
      check_eq("d_first_x", 32'(x_d), 32'd0);
      check_eq("d_first_y", 32'(y_d), 32'd0);
      first_low = -1; low_len = 0; period = -1;
      for (int c = 1; c <= 1100; c++) begin
         @(negedge sys_clk);
         if (!hs_d) begin
            if (first_low < 0) first_low = c;
            low_len++;
         end
         if (c == 500) check_eq("d_pix_ce_en", 32'(pce_d), 32'd1);
         if (c == 799) check_eq("d_x_last", {21'd0, x_d}, 32'd799);
         if (c == 799) check_eq("d_blank_vis", 32'(bl_d), 32'd0);
         if (c == 800) check_eq("d_x_blank", {21'd0, x_d}, 32'h7ff);
         if (c == 800) check_eq("d_blank_hb", 32'(bl_d), 32'd1);
         if (ls_d && period < 0) begin
            period = c;
            check_eq("d_line2_y", {21'd0, y_d}, 32'd1);
            check_eq("d_line2_fs", 32'(fs_d), 32'd0);
            check_eq("d_line2_vs", 32'(vs_d), 32'd1);
         end
      end
      check_eq("d_line_period", 32'(period), 32'd1040);
      check_eq("d_hsync_start", 32'(first_low), 32'd856);
      check_eq("d_hsync_len", 32'(low_len), 32'd120);
      check_eq("d_frame_cnt", 32'(fc_d), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
